// File: rtl/msrv32_dport_arbiter_if.sv
// Bundle of the requester-side and AHB-Lite-side signals of the data-port
// arbiter. The arbiter connects through the master modport; the environment
// (requesters plus bus slave) connects through the slave modport.
//
// Handshake rules:
//   - A requester raises *_req_in with stable addr/data/size and keeps it
//     high until its *_ack_out pulse. The ack is a one-cycle pulse, and
//     err_out is valid only in that same cycle.
//   - On the bus, an address phase is accepted, and a data phase completes,
//     in any cycle with hready_in=1. hresp_in is sampled only when a data
//     phase completes.
interface msrv32_dport_arbiter_if;
  // store requester
  logic        st_req_in;
  logic [31:0] st_addr_in;
  logic [31:0] st_data_in;
  logic [1:0]  st_size_in;
  // load requester
  logic        ld_req_in;
  logic [31:0] ld_addr_in;
  logic [1:0]  ld_size_in;
  // requester responses
  logic        st_ack_out;
  logic        ld_ack_out;
  logic [31:0] ld_data_out;
  logic        err_out;
  logic        stall_out;
  // AHB-Lite master side
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [31:0] hwdata_out;
  logic        hready_in;
  logic        hresp_in;
  logic [31:0] hrdata_in;

  modport master (
    input  st_req_in, st_addr_in, st_data_in, st_size_in,
    input  ld_req_in, ld_addr_in, ld_size_in,
    output st_ack_out, ld_ack_out, ld_data_out, err_out, stall_out,
    output haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out,
    input  hready_in, hresp_in, hrdata_in
  );

  modport slave (
    output st_req_in, st_addr_in, st_data_in, st_size_in,
    output ld_req_in, ld_addr_in, ld_size_in,
    input  st_ack_out, ld_ack_out, ld_data_out, err_out, stall_out,
    input  haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out,
    output hready_in, hresp_in, hrdata_in
  );
endinterface

// File: rtl/msrv32_dport_arbiter.sv
// Data-port arbiter: shares one AHB-Lite master port between a store and a
// load requester. There is one non-overlapped transfer at a time
// (IDLE -> ADDR -> DATA -> IDLE). A tie is broken by alternation. Misaligned
// requests are rejected without touching the bus. A stuck slave is abandoned
// after WAIT_TIMEOUT wait states.
module msrv32_dport_arbiter #(
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  msrv32_dport_arbiter_if.master bus,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);

  logic [1:0]    state;
  logic          last_grant_st;  // 1: store was granted last, 0: load
  logic [31:0]   lat_addr;
  logic [31:0]   lat_data;
  logic [2:0]    lat_size;
  logic          lat_write;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;
  logic          timeout;
  logic          st_ack_q;
  logic          ld_ack_q;
  logic          err_q;
  logic [31:0]   ld_data_q;

  logic          st_eff;
  logic          ld_eff;
  logic          grant_st;
  logic          grant_ld;
  logic [31:0]   win_addr;
  logic [1:0]    win_size;
  logic          misaligned;

  // A requester still shows its request in its own ack cycle, before it has
  // seen the ack. Masking it there keeps a completed request from being
  // granted a second time. The other requester can still win in that cycle,
  // so back-to-back transfers need no idle cycle.
  assign st_eff   = bus.st_req_in & ~st_ack_q;
  assign ld_eff   = bus.ld_req_in & ~ld_ack_q;
  assign grant_st = st_eff & (~ld_eff | ~last_grant_st);
  assign grant_ld = ld_eff & ~grant_st;
  assign win_addr = grant_st ? bus.st_addr_in : bus.ld_addr_in;
  assign win_size = grant_st ? bus.st_size_in : bus.ld_size_in;

  assign wait_nxt = wait_cnt + CW'(1);
  assign timeout  = (wait_nxt == CW'(WAIT_TIMEOUT));

  // Alignment check on the winning request; funct3 size 11 behaves as word.
  always_comb begin
    misaligned = 1'b0;
    case (win_size)
      2'b01:   misaligned = win_addr[0];
      2'b10,
      2'b11:   misaligned = (win_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Transfer sequencing, latching of the granted request, and response pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      last_grant_st <= 1'b0;
      lat_addr      <= '0;
      lat_data      <= '0;
      lat_size      <= '0;
      lat_write     <= 1'b0;
      wait_cnt      <= '0;
      st_ack_q      <= 1'b0;
      ld_ack_q      <= 1'b0;
      err_q         <= 1'b0;
      ld_data_q     <= '0;
    end else begin
      st_ack_q <= 1'b0;
      ld_ack_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_st || grant_ld) begin
            last_grant_st <= grant_st;
            if (misaligned) begin
              st_ack_q <= grant_st;
              ld_ack_q <= grant_ld;
              err_q    <= 1'b1;
            end else begin
              lat_addr  <= win_addr;
              lat_data  <= grant_st ? bus.st_data_in : 32'h0;
              lat_size  <= (win_size == 2'b11) ? 3'b010 : {1'b0, win_size};
              lat_write <= grant_st;
              wait_cnt  <= '0;
              state     <= ADDR;
            end
          end
        end
        ADDR: begin
          if (bus.hready_in) begin
            wait_cnt <= '0;
            state    <= DATA;
          end else if (timeout) begin
            st_ack_q <= lat_write;
            ld_ack_q <= ~lat_write;
            err_q    <= 1'b1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        DATA: begin
          if (bus.hready_in) begin
            st_ack_q <= lat_write;
            ld_ack_q <= ~lat_write;
            err_q    <= bus.hresp_in;
            if (!lat_write && !bus.hresp_in) begin
              ld_data_q <= bus.hrdata_in;
            end
            state <= IDLE;
          end else if (timeout) begin
            st_ack_q <= lat_write;
            ld_ack_q <= ~lat_write;
            err_q    <= 1'b1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.htrans_out  = (state == ADDR) ? 2'b10 : 2'b00;
  assign bus.haddr_out   = lat_addr;
  assign bus.hwrite_out  = lat_write;
  assign bus.hsize_out   = lat_size;
  assign bus.hwdata_out  = (state == DATA) ? lat_data : 32'h0;
  assign bus.st_ack_out  = st_ack_q;
  assign bus.ld_ack_out  = ld_ack_q;
  assign bus.err_out     = err_q;
  assign bus.ld_data_out = ld_data_q;
  // Gated by reset so that stall reads 0 while reset is held, even with
  // requests up.
  assign bus.stall_out   = rst_n_in & ((state != IDLE) | st_eff | ld_eff);
  assign state_dbg       = state;

endmodule

// File: doc/msrv32_dport_arbiter.md
MSRV32_DPORT_ARBITER -- requirements
Module: msrv32_dport_arbiter

Interface
REQ-001 SHALL provide parameter WAIT_TIMEOUT, default 15: number of consecutive hready_in=0 cycles in one transfer before the transfer is aborted.
REQ-002 SHALL provide port clk_in, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n_in, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL provide store-requester inputs: st_req_in (1, level request), st_addr_in (32, byte address), st_data_in (32, lane-aligned write data), st_size_in (2, funct3[1:0]).
REQ-005 SHALL provide load-requester inputs: ld_req_in (1, level request), ld_addr_in (32, byte address), ld_size_in (2, funct3[1:0]).
REQ-006 SHALL provide requester outputs: st_ack_out (1), ld_ack_out (1), ld_data_out (32), err_out (1), stall_out (1).
REQ-007 SHALL provide AHB-Lite master outputs: haddr_out (32), htrans_out (2), hwrite_out (1), hsize_out (3), hwdata_out (32).
REQ-008 SHALL provide AHB-Lite master inputs: hready_in (1), hresp_in (1), hrdata_in (32).

Function
REQ-009 SHALL implement the state machine IDLE -> ADDR -> DATA -> IDLE; at most one transfer is outstanding, and there is no address/data overlap.
REQ-010 SHALL arbitrate in IDLE when any request is high, latching the winner's address, data, size and direction into registers; entry to ADDR occurs on the next edge.
REQ-011 SHALL grant the sole requester when only one request is high, and SHALL alternate when both are high, granting the requester not granted last (last_grant register; store wins the first tie after reset).
REQ-012 SHALL, in ADDR, drive htrans_out=2'b10 with haddr_out, hwrite_out (1=store) and hsize_out from the latched values, and advance to DATA on hready_in=1.
REQ-013 SHALL drive htrans_out=2'b00 in IDLE and DATA.
REQ-014 SHALL map hsize_out = {1'b0, size}, with size 2'b11 treated as word (3'b010).
REQ-015 SHALL, in DATA, drive hwdata_out with the latched store data (0 for loads), and complete the transfer on hready_in=1 by returning to IDLE.
REQ-016 SHALL, on a load completion, register hrdata_in into ld_data_out; ld_data_out SHALL hold its value otherwise.
REQ-017 SHALL pulse st_ack_out or ld_ack_out (matching the granted requester) for exactly one cycle, on the cycle after completion.
REQ-018 SHALL give a minimum request-to-ack latency of 3 cycles with zero wait states.
REQ-019 SHALL treat hresp_in=1 at completion as a failed transfer: err_out pulses together with the ack, and ld_data_out is not updated.
REQ-020 SHALL abort a transfer when its wait-state counter (reset on entry to ADDR and DATA, incremented each hready_in=0 cycle) reaches WAIT_TIMEOUT: return to IDLE, htrans_out=00, ack+err_out pulse next cycle.
REQ-021 SHALL detect misaligned requests (halfword with addr[0]=1; word with addr[1:0]!=0) in IDLE and SHALL issue no bus transfer for them; ack+err_out pulse next cycle, last_grant updated.
REQ-022 SHALL require requesters to hold req/addr/data stable until their ack; a request deasserted before its ack is still completed once latched.
REQ-023 SHALL drive stall_out=1 whenever state!=IDLE, or state==IDLE with any request high; stall_out SHALL be 0 in the ack cycle only if no new request is pending.
REQ-024 SHALL allow a new arbitration in the same cycle an ack pulses, without an extra idle cycle.

Reset
REQ-025 SHALL, while rst_n_in=0, force state=IDLE, htrans_out=2'b00, hwrite_out=0, haddr_out=0, hsize_out=0, hwdata_out=0, all acks=0, err_out=0, stall_out=0, ld_data_out=0, last_grant=load, wait counter=0.
REQ-026 SHALL, on reset asserted mid-transfer (ADDR or DATA), abandon the transfer immediately with no ack and no err_out; requesters reissue after reset.

Verification
REQ-027 SHALL cover a single store: st_req=1, addr=0x100, size=10, data=0xDEADBEEF, hready=1 -> htrans=10/haddr=0x100/hwrite=1/hsize=010 in cycle 1, hwdata=0xDEADBEEF in cycle 2, st_ack pulse in cycle 3.
REQ-028 SHALL cover simultaneous requests after reset: st_req=ld_req=1 held -> store granted first, load second, with acks exactly one ack-spacing apart (no idle gap).
REQ-029 SHALL cover a load with 2 wait states: ld addr=0x204, hready=0 for 2 DATA cycles, hrdata=0x12345678 -> ld_ack 5 cycles after the request, ld_data_out=0x12345678.
REQ-030 SHALL cover an error response: hresp=1 with hready=1 in DATA for a load -> ld_ack and err_out pulse together, ld_data_out unchanged.
REQ-031 SHALL cover timeout and misalignment: hready held 0 for WAIT_TIMEOUT cycles -> abort, err_out+ack; halfword store at 0x101 -> no htrans=10, err_out+st_ack next cycle.
REQ-032 SHALL cover reset in DATA: assert rst_n_in=0 while in DATA -> htrans=00 and all outputs at reset values asynchronously, no ack.
